// File: rtl/rgb2dram_if.sv
// Pixel-pipeline and DRAM write-buffer signals of the rgb2dram write-back block.
// "final" is a reserved word, so the frame-complete flag is carried as final_flag.
interface rgb2dram_if;
   logic [31:0] rgb_in;
   logic        rgb_we;
   logic [31:0] addr_in;
   logic        addr_we;
   logic        rgb_full;
   logic        addr_full;
   logic [7:0]  rgb_cnt;
   logic        frame_select;
   logic        kick;
   logic        busy;
   logic [31:0] write_num;
   logic [31:0] write_addr;
   logic        buf_re;
   logic [31:0] buf_dout;
   logic        final_flag;
   logic        err;

   modport slave (
      input  rgb_in, rgb_we, addr_in, addr_we, frame_select, busy, buf_re,
      output rgb_full, addr_full, rgb_cnt, kick, write_num, write_addr,
             buf_dout, final_flag, err
   );

   modport master (
      output rgb_in, rgb_we, addr_in, addr_we, frame_select, busy, buf_re,
      input  rgb_full, addr_full, rgb_cnt, kick, write_num, write_addr,
             buf_dout, final_flag, err
   );
endinterface

// File: rtl/rgb2dram.sv
// Write-back stage: stages pixel words and burst offsets, then issues fixed-length
// kick/busy write bursts to the DRAM controller until the frame's last burst is done.
//
// state  | meaning
// S_IDLE | wait for a full burst of data, an offset and an idle controller
// S_KICK | kick asserted, write_addr valid, waiting for busy
// S_XFER | controller draining the burst, pops counted
// S_DONE | one cycle to decide whether the frame is complete
// S_END  | frame written, final_flag held until reset
module rgb2dram #(
   parameter int          AMOUNT_OF_ONCE = 64,
   parameter int          DEPTH          = 128,
   parameter logic [31:0] OFFSET_END     = 32'd1440000,
   parameter logic [31:0] FRAME0_BASE    = 32'h0000_0000,
   parameter logic [31:0] FRAME1_BASE    = 32'h0100_0000
) (
   input logic      clk,
   input logic      rst_n,
   rgb2dram_if.slave bus
);

   localparam int          PW         = $clog2(DEPTH);
   localparam int          AW         = $clog2(AMOUNT_OF_ONCE);
   localparam logic [7:0]  DEPTH_C    = 8'(DEPTH);
   localparam logic [7:0]  AMOUNT_C   = 8'(AMOUNT_OF_ONCE);
   localparam logic [7:0]  FULL_TH    = 8'(DEPTH - AMOUNT_OF_ONCE);
   localparam logic [AW:0] BURST_LAST = (AW+1)'(AMOUNT_OF_ONCE);

   typedef enum logic [2:0] {S_IDLE, S_KICK, S_XFER, S_DONE, S_END} state_t;

   state_t state, state_n;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [7:0]    cnt;
   logic          push_ok, pop_ok;

   logic [31:0]   off_mem [4];
   logic [1:0]    off_wr, off_rd;
   logic [2:0]    off_cnt;
   logic          off_push_ok;
   logic [31:0]   off_head;

   logic [31:0]   cur_off;
   logic [31:0]   write_addr_r;
   logic [AW:0]   burst_cnt;
   logic          burst_full;
   logic          start;
   logic          err_r;
   logic          err_set;

   assign push_ok     = bus.rgb_we && (cnt != DEPTH_C);
   assign pop_ok      = bus.buf_re && (cnt != 8'd0);
   assign off_push_ok = bus.addr_we && (off_cnt != 3'd4);
   assign off_head    = off_mem[off_rd];
   assign burst_full  = (burst_cnt == BURST_LAST);

   always_ff @(posedge clk) begin
      if (push_ok)     mem[wr_ptr]     <= bus.rgb_in;
      if (off_push_ok) off_mem[off_wr] <= bus.addr_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= 8'd0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 8'd1;
            2'b01:   cnt <= cnt - 8'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_wr  <= 2'd0;
         off_rd  <= 2'd0;
         off_cnt <= 3'd0;
      end else begin
         if (off_push_ok) off_wr <= off_wr + 2'd1;
         if (start)       off_rd <= off_rd + 2'd1;
         case ({off_push_ok, start})
            2'b10:   off_cnt <= off_cnt + 3'd1;
            2'b01:   off_cnt <= off_cnt - 3'd1;
            default: off_cnt <= off_cnt;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!bus.busy && (cnt >= AMOUNT_C) && (off_cnt != 3'd0)) begin
               start   = 1'b1;
               state_n = S_KICK;
            end
         end
         S_KICK: if (bus.busy) state_n = S_XFER;
         S_XFER: if (burst_full && !bus.busy) state_n = S_DONE;
         S_DONE: state_n = (cur_off + 32'(AMOUNT_OF_ONCE) == OFFSET_END) ? S_END : S_IDLE;
         S_END:  state_n = S_END;
         default: state_n = S_IDLE;
      endcase
   end

   // Errors: overflow, underflow, misaligned offset, or pops past the burst length.
   assign err_set = (bus.rgb_we && (cnt == DEPTH_C))
                  || (bus.buf_re && (cnt == 8'd0))
                  || (bus.addr_we && (bus.addr_in[AW-1:0] != '0))
                  || (bus.addr_we && (off_cnt == 3'd4))
                  || ((state == S_XFER) && bus.buf_re && burst_full);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cur_off      <= 32'd0;
         write_addr_r <= FRAME1_BASE;
         burst_cnt    <= '0;
         err_r        <= 1'b0;
      end else begin
         state <= state_n;
         if (err_set) err_r <= 1'b1;
         if (start) begin
            cur_off      <= off_head;
            write_addr_r <= (off_head << 2) + (bus.frame_select ? FRAME0_BASE : FRAME1_BASE);
            burst_cnt    <= '0;
         end else if ((state == S_XFER) && pop_ok && !burst_full) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   assign bus.rgb_full   = (cnt > FULL_TH);
   assign bus.addr_full  = (off_cnt == 3'd4);
   assign bus.rgb_cnt    = cnt;
   assign bus.kick       = (state == S_KICK);
   assign bus.write_num  = 32'(AMOUNT_OF_ONCE);
   assign bus.write_addr = write_addr_r;
   assign bus.buf_dout   = (cnt == 8'd0) ? 32'd0 : mem[rd_ptr];
   assign bus.final_flag = (state == S_END);
   assign bus.err        = err_r;

endmodule

// File: tb/tb_rgb2dram.sv
// Directed bench for rgb2dram: a table of write bursts plus hand-written
// sequences for reset, overflow, underflow, misalignment and reset mid-burst.
module tb_rgb2dram;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rgb2dram_if bus();

   rgb2dram dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] off;
      logic        fsel;
      logic [31:0] dbase;
      logic [31:0] exp_addr;
      logic        exp_final;
   } burst_vec_t;

   burst_vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.rgb_in       = 32'd0;
      bus.rgb_we       = 1'b0;
      bus.addr_in      = 32'd0;
      bus.addr_we      = 1'b0;
      bus.frame_select = 1'b0;
      bus.busy         = 1'b0;
      bus.buf_re       = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_kick"},       {31'd0, bus.kick},       32'd0);
      check({tag, "_final"},      {31'd0, bus.final_flag}, 32'd0);
      check({tag, "_err"},        {31'd0, bus.err},        32'd0);
      check({tag, "_write_addr"}, bus.write_addr,          32'h0100_0000);
      check({tag, "_buf_dout"},   bus.buf_dout,            32'd0);
      check({tag, "_rgb_cnt"},    {24'd0, bus.rgb_cnt},    32'd0);
      check({tag, "_rgb_full"},   {31'd0, bus.rgb_full},   32'd0);
      check({tag, "_addr_full"},  {31'd0, bus.addr_full},  32'd0);
      check({tag, "_write_num"},  bus.write_num,           32'd64);
   endtask

   // Assert reset away from any clock edge and check outputs before the next edge.
   task automatic mid_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      clear_inputs();
      #1;
      check_reset_vals(tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push_off(input logic [31:0] off);
      bus.addr_in = off;
      bus.addr_we = 1'b1;
      tick();
      bus.addr_we = 1'b0;
   endtask

   task automatic push_words(input logic [31:0] base, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         bus.rgb_in = base + 32'(first + i);
         bus.rgb_we = 1'b1;
         tick();
      end
      bus.rgb_we = 1'b0;
   endtask

   task automatic wait_kick(input string tag);
      int n = 0;
      while (!bus.kick && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_kick_seen"}, {31'd0, bus.kick}, 32'd1);
   endtask

   task automatic pop_words(input string tag, input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_dout"}, bus.buf_dout, base + 32'(i));
         bus.buf_re = 1'b1;
         tick();
      end
      bus.buf_re = 1'b0;
   endtask

   task automatic run_burst(input string tag, input burst_vec_t v);
      bus.frame_select = v.fsel;
      push_off(v.off);
      push_words(v.dbase, 0, 63);
      repeat (3) tick();
      check({tag, "_no_early_kick"}, {31'd0, bus.kick}, 32'd0);
      push_words(v.dbase, 63, 1);
      wait_kick(tag);
      check({tag, "_write_addr"}, bus.write_addr, v.exp_addr);
      bus.busy = 1'b1;
      tick();
      pop_words(tag, v.dbase, 64);
      bus.busy = 1'b0;
      repeat (3) tick();
      check({tag, "_err"},     {31'd0, bus.err},        32'd0);
      check({tag, "_final"},   {31'd0, bus.final_flag}, {31'd0, v.exp_final});
      check({tag, "_kick_lo"}, {31'd0, bus.kick},       32'd0);
      check({tag, "_rgb_cnt"}, {24'd0, bus.rgb_cnt},    32'd0);
   endtask

   initial begin
      vecs[0] = '{off: 32'd0,       fsel: 1'b1, dbase: 32'h0000_0000, exp_addr: 32'h0000_0000, exp_final: 1'b0};
      vecs[1] = '{off: 32'd64,      fsel: 1'b0, dbase: 32'hA000_0000, exp_addr: 32'h0100_0100, exp_final: 1'b0};
      vecs[2] = '{off: 32'd128,     fsel: 1'b0, dbase: 32'hB000_0000, exp_addr: 32'h0100_0200, exp_final: 1'b0};
      vecs[3] = '{off: 32'd1439936, fsel: 1'b1, dbase: 32'hC000_0000, exp_addr: 32'h0057_E300, exp_final: 1'b1};

      clear_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("init_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 4; k++) begin
         run_burst($sformatf("burst%0d", k), vecs[k]);
      end

      // After the frame ends, data is still accepted but never written out.
      push_off(32'd0);
      push_words(32'hD000_0000, 0, 64);
      repeat (10) tick();
      check("end_no_kick",  {31'd0, bus.kick},       32'd0);
      check("end_final",    {31'd0, bus.final_flag}, 32'd1);
      check("end_rgb_cnt",  {24'd0, bus.rgb_cnt},    32'd64);

      mid_reset("rst_after_end");

      push_words(32'h0, 0, 128);
      check("ovf_err_before", {31'd0, bus.err},      32'd0);
      check("ovf_full_128",   {31'd0, bus.rgb_full}, 32'd1);
      push_words(32'h0, 128, 1);
      check("ovf_err",        {31'd0, bus.err},      32'd1);
      check("ovf_cnt",        {24'd0, bus.rgb_cnt},  32'd128);
      check("ovf_kick",       {31'd0, bus.kick},     32'd0);

      mid_reset("rst_after_ovf");

      bus.buf_re = 1'b1;
      tick();
      bus.buf_re = 1'b0;
      check("unf_err",  {31'd0, bus.err},     32'd1);
      check("unf_dout", bus.buf_dout,         32'd0);
      check("unf_cnt",  {24'd0, bus.rgb_cnt}, 32'd0);

      mid_reset("rst_after_unf");

      bus.rgb_in = 32'h1234_5678;
      bus.rgb_we = 1'b1;
      bus.buf_re = 1'b1;
      tick();
      bus.rgb_we = 1'b0;
      bus.buf_re = 1'b0;
      check("nobypass_err",  {31'd0, bus.err},     32'd1);
      check("nobypass_cnt",  {24'd0, bus.rgb_cnt}, 32'd1);
      check("nobypass_dout", bus.buf_dout,         32'h1234_5678);

      mid_reset("rst_after_nobypass");

      push_off(32'd5);
      check("misalign_err", {31'd0, bus.err}, 32'd1);

      mid_reset("rst_after_misalign");

      push_off(32'd0);
      push_off(32'd64);
      push_off(32'd128);
      check("afull_3",      {31'd0, bus.addr_full}, 32'd0);
      push_off(32'd192);
      check("afull_4",      {31'd0, bus.addr_full}, 32'd1);
      check("afull_err_lo", {31'd0, bus.err},       32'd0);
      push_off(32'd256);
      check("afull_ovf_err", {31'd0, bus.err},       32'd1);
      check("afull_still",   {31'd0, bus.addr_full}, 32'd1);

      mid_reset("rst_after_afull");

      bus.frame_select = 1'b1;
      push_off(32'd0);
      push_words(32'hE000_0000, 0, 64);
      wait_kick("part");
      bus.busy = 1'b1;
      tick();
      pop_words("part", 32'hE000_0000, 20);
      check("part_cnt", {24'd0, bus.rgb_cnt}, 32'd44);
      mid_reset("rst_mid_xfer");

      run_burst("after_rst", '{off: 32'd64, fsel: 1'b1, dbase: 32'hF000_0000,
                               exp_addr: 32'h0000_0100, exp_final: 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
